// File: rtl/coin_pkg.sv
// Shared coin codes, FSM state encoding and coin-type helper for the coin acceptor.
// No logic, so no latency and no backpressure.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        MEAS,
        STUCK,
        LOCK
    } state_t;

    typedef enum logic {
        TYPE_5,
        TYPE_10
    } coin_type_t;

    function automatic logic [1:0] type_code(input coin_type_t t);
        return (t == TYPE_10) ? COIN_10 : COIN_5;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus level debouncer for one raw coin sensor line.
// Latency: raw edge to debounced edge is 2 + DEB_CYCLES clocks.
// Backpressure: none; the line is sampled every clock.
module coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic db_out
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // Any sample that agrees with the current level restarts the run.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounced 5/10 Rs sensors to one-cycle coin codes or reject pulses.
// Latency: coin_code/reject one clock after the debounced falling edge (2+DEB_CYCLES after raw).
// Backpressure: none; downstream must sample coin_code and reject every clock.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int MIN_PULSE  = 8,
    parameter int MAX_PULSE  = 64,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_in,
    input  logic       coin10_in,
    output logic [1:0] coin_code,
    output logic       reject,
    output logic       busy,
    output logic [7:0] coin_cnt
);

    localparam int WW = $clog2(MAX_PULSE + 2);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [WW-1:0] W_MIN  = WW'(MIN_PULSE);
    localparam logic [WW-1:0] W_MAX  = WW'(MAX_PULSE);
    localparam logic [WW-1:0] W_SAT  = WW'(MAX_PULSE + 1);
    localparam logic [GW-1:0] G_DONE = GW'(GAP_CYCLES);

    logic db5, db10;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb5 (
        .clk    (clk),
        .rst    (rst),
        .raw_in (coin5_in),
        .db_out (db5)
    );

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb10 (
        .clk    (clk),
        .rst    (rst),
        .raw_in (coin10_in),
        .db_out (db10)
    );

    state_t     state_q, state_d;
    coin_type_t type_q, type_d;
    logic [WW-1:0] width_q, width_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    coin_code_q, coin_code_d;
    logic          reject_q, reject_d;
    logic [7:0]    coin_cnt_q, coin_cnt_d;
    logic          db5_prev_q, db10_prev_q;

    logic rise5, rise10, both_low, active_hi, other_rise;

    assign rise5      = db5 & ~db5_prev_q;
    assign rise10     = db10 & ~db10_prev_q;
    assign both_low   = ~db5 & ~db10;
    assign active_hi  = (type_q == TYPE_5) ? db5 : db10;
    assign other_rise = (type_q == TYPE_5) ? rise10 : rise5;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        width_d     = width_q;
        gap_d       = gap_q;
        coin_code_d = COIN_NONE;
        reject_d    = 1'b0;
        coin_cnt_d  = coin_cnt_q;

        case (state_q)
            // Lines must stay low for a full gap so a sensor held high through
            // reset has time to reach the debounced level before IDLE is entered.
            WAIT_LOW: begin
                if (!both_low) begin
                    gap_d = '0;
                end else if (gap_q != G_DONE) begin
                    gap_d = gap_q + 1'b1;
                end else begin
                    gap_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise5 && rise10) begin
                    reject_d = 1'b1;
                    state_d  = STUCK;
                end else if (rise5) begin
                    type_d  = TYPE_5;
                    width_d = WW'(1);
                    state_d = MEAS;
                end else if (rise10) begin
                    type_d  = TYPE_10;
                    width_d = WW'(1);
                    state_d = MEAS;
                end
            end
            MEAS: begin
                if (other_rise) begin
                    reject_d = 1'b1;
                    state_d  = STUCK;
                end else if (active_hi) begin
                    if (width_q != W_SAT) begin
                        width_d = width_q + 1'b1;
                    end
                    if (width_d == W_SAT) begin
                        reject_d = 1'b1;
                        state_d  = STUCK;
                    end
                end else begin
                    if (width_q >= W_MIN && width_q <= W_MAX) begin
                        coin_code_d = type_code(type_q);
                        coin_cnt_d  = coin_cnt_q + 8'd1;
                    end else begin
                        reject_d = 1'b1;
                    end
                    gap_d   = '0;
                    state_d = LOCK;
                end
            end
            STUCK: begin
                if (both_low) begin
                    gap_d   = '0;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (gap_q != G_DONE) begin
                    gap_d = gap_q + 1'b1;
                end else if (both_low) begin
                    state_d = IDLE;
                end
            end
            default: begin
                gap_d   = '0;
                state_d = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= WAIT_LOW;
            type_q      <= TYPE_5;
            width_q     <= '0;
            gap_q       <= '0;
            coin_code_q <= COIN_NONE;
            reject_q    <= 1'b0;
            coin_cnt_q  <= 8'd0;
            db5_prev_q  <= 1'b0;
            db10_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            coin_code_q <= coin_code_d;
            reject_q    <= reject_d;
            coin_cnt_q  <= coin_cnt_d;
            db5_prev_q  <= db5;
            db10_prev_q <= db10;
        end
    end

    assign coin_code = coin_code_q;
    assign reject    = reject_q;
    assign busy      = (state_q != IDLE);
    assign coin_cnt  = coin_cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected events are queued as coins are driven
// and matched against every non-zero coin_code / reject cycle.
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int EV_5   = 1;
    localparam int EV_10  = 2;
    localparam int EV_REJ = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin5_in = 1'b0;
    logic       coin10_in = 1'b0;
    logic [1:0] coin_code;
    logic       reject;
    logic       busy;
    logic [7:0] coin_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_q[$];
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk       (clk),
        .rst       (rst),
        .coin5_in  (coin5_in),
        .coin10_in (coin10_in),
        .coin_code (coin_code),
        .reject    (reject),
        .busy      (busy),
        .coin_cnt  (coin_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every output event must match the oldest queued expectation.
    always @(negedge clk) begin
        int obs;
        int e;
        if (rst && (coin_code != COIN_NONE || reject)) begin
            obs = reject ? EV_REJ : int'(coin_code);
            chk("code_rej_excl", int'(coin_code != COIN_NONE && reject), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", obs, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event", obs, e);
                if (e != EV_REJ) exp_cnt = exp_cnt + 8'd1;
                chk("coin_cnt", int'(coin_cnt), int'(exp_cnt));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int line, input int n);
        if (line == 5) coin5_in = 1'b1;
        else           coin10_in = 1'b1;
        cyc(n);
        coin5_in  = 1'b0;
        coin10_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            cyc(1);
            i++;
        end
        chk("idle", int'(busy), 0);
    endtask

    task automatic settle();
        cyc(30);
        wait_idle(300);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        cyc(3);
        chk("rst_code", int'(coin_code), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cnt", int'(coin_cnt), 0);
        rst = 1'b1;
        wait_idle(100);

        // Valid 5 Rs coin.
        exp_q.push_back(EV_5);
        pulse(5, 20);
        settle();

        // Short glitches on the 10 Rs line never reach the debounced level.
        repeat (5) begin
            coin10_in = 1'b1;
            cyc(2);
            coin10_in = 1'b0;
            cyc(3);
        end
        settle();

        // Too-short pulse, and the pulse-width boundaries.
        exp_q.push_back(EV_REJ);
        pulse(5, 5);
        settle();
        exp_q.push_back(EV_REJ);
        pulse(5, 7);
        settle();
        exp_q.push_back(EV_5);
        pulse(5, 8);
        settle();
        exp_q.push_back(EV_10);
        pulse(10, 64);
        settle();
        exp_q.push_back(EV_REJ);
        pulse(10, 65);
        settle();

        // Both chutes together, then a 10 Rs line stuck high.
        exp_q.push_back(EV_REJ);
        coin5_in  = 1'b1;
        coin10_in = 1'b1;
        cyc(20);
        coin5_in  = 1'b0;
        coin10_in = 1'b0;
        settle();
        exp_q.push_back(EV_REJ);
        pulse(10, 100);
        settle();

        // Second coin arriving inside the lockout is ignored.
        exp_q.push_back(EV_10);
        pulse(10, 20);
        i = 0;
        while (coin_code == COIN_NONE && i < 50) begin
            cyc(1);
            i++;
        end
        chk("accept_seen", int'(coin_code), int'(COIN_10));
        cyc(4);
        pulse(5, 20);
        settle();

        // Reset in the middle of a coin, line held high after release.
        coin5_in = 1'b1;
        cyc(10);
        rst = 1'b0;
        cyc(3);
        exp_cnt = 8'd0;
        chk("midrst_cnt", int'(coin_cnt), 0);
        chk("midrst_busy", int'(busy), 1);
        rst = 1'b1;
        cyc(40);
        coin5_in = 1'b0;
        settle();
        exp_q.push_back(EV_5);
        pulse(5, 20);
        settle();
        chk("post_rst_cnt", int'(coin_cnt), 1);

        // 255 more accepts wrap the counter back to zero.
        for (int k = 0; k < 255; k++) begin
            exp_q.push_back((k % 2 == 1) ? EV_10 : EV_5);
            pulse((k % 2 == 1) ? 10 : 5, 12);
            cyc(10);
            wait_idle(100);
        end
        settle();
        chk("cnt_wrap", int'(coin_cnt), 0);
        chk("cnt_model", int'(coin_cnt), int'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
